bridge_tx_arbiter: RTL and testbench
====================================

Name: bridge_tx_arbiter

Overview:
- Shares the single PCIe transmit path between three TLP requesters: posted writes, non-posted reads, and completions.
- Grants one requester at a time, round-robin, and only when the core-reported flow-control credits cover that request's header and data.
- After each TLP it holds off for a settle window so the core credit counters reflect the consumption before the next grant.
- Sits between the bridge control block (ready, credit inputs) and the Tx bridge.

Parameters:
- LEN_W, 10: TLP length field width in DW; a value of 0 encodes 1024 DW.
- SETTLE_CYCLES, 4: idle cycles after each TLP before re-arbitration; must be >= 1.
- TIMEOUT_CYCLES, 1024: maximum GRANT duration before a forced release.
- CNT_W, 11: width of the settle and timeout counters; must satisfy 2^CNT_W >= TIMEOUT_CYCLES.

Ports:
- Arb_CLK, in, 1: clock; all logic is synchronous to it.
- Arb_RST, in, 1: reset, asynchronous, active-low; driven from Ctrl_Bridge_RST.
- Arb_Ready, in, 1: from control; while low, no new grant is issued.
- Arb_Req, in, 3: request per type. [0] = posted, [1] = non-posted, [2] = completion.
- Arb_Req_Data, in, 3: per type, 1 when the TLP carries payload.
- Arb_Req_Len, in, 3*LEN_W: per-type length in DW, packed with type 0 in the LSBs.
- Arb_Done, in, 1: Tx bridge pulse on the last beat of the granted TLP.
- Arb_fc_ph / Arb_fc_nph / Arb_fc_cplh, in, 8 each: available header credits.
- Arb_fc_pd / Arb_fc_npd / Arb_fc_cpld, in, 12 each: available data credits.
- Arb_fc_sel, out, 3: flow-control view select to the core.
- Arb_Gnt, out, 3: one-hot grant, registered.
- Arb_Busy, out, 1: high in any state other than IDLE.
- Arb_Blocked, out, 3: per type, request pending but credit-starved.
- Arb_Timeout, out, 1: one-cycle pulse on a forced release.

Behaviour:
- Reset values (async, Arb_RST low):
  - Arb_Gnt = 0, Arb_Blocked = 0, Arb_Timeout = 0, Arb_Busy = 0.
  - Arb_fc_sel = 3'b100 (Tx available space), held constant thereafter.
  - State = IDLE, round-robin pointer = 0, counters = 0.
- Credit need for type i:
  - Header: 1 credit.
  - Data: if Arb_Req_Data[i] = 0, zero. Otherwise ceil(len/4), computed as (len+3)>>2 at LEN_W+1 bits; len = 0 is treated as 1024, giving 256 credits.
  - Type i is eligible when Req[i] = 1, its header credit count != 0, and its data credit count >= data need (unsigned compare).
- Round-robin: the search starts at the pointer and proceeds i, i+1, i+2 mod 3. On a grant to type i, the pointer becomes (i+1) mod 3.
- State IDLE:
  - If Arb_Ready and |Arb_Req at an edge, go to CHECK.
- State CHECK (one cycle; credit inputs sampled here):
  - If Arb_Ready is now low, return to IDLE with no grant.
  - Else if any type is eligible, go to GRANT and register Arb_Gnt for the round-robin winner. Arb_Gnt is high on the second edge after Req is first seen in IDLE.
  - Else go to IDLE and set Arb_Blocked[i] for every requesting, ineligible type.
- State GRANT:
  - Arb_Gnt is held constant; the timeout counter increments each cycle.
  - Arb_Done sampled high: clear Arb_Gnt, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - Counter reaches TIMEOUT_CYCLES-1 without Done: same exit, plus a 1-cycle Arb_Timeout pulse.
  - Done and timeout on the same edge: Done wins, no Timeout pulse.
  - Req withdrawal during GRANT is ignored; Arb_Ready low during GRANT does not cut the grant.
- State SETTLE:
  - Decrement each cycle; when the counter is 0, go to IDLE.
  - Arb_Done outside GRANT is ignored.
- Arb_Blocked[i] clears when Req[i] is deasserted or type i is granted. Bits for other types are re-evaluated in each CHECK.
- Requester contract: Len and Data stay stable while Req is high until granted. Deasserting Req before the grant withdraws the request.

Decomposition:
- Package bridge_pkg holds:
  - Type index constants (posted 0, non-posted 1, completion 2).
  - FC_SEL_TX_AVAIL = 3'b100.
  - The state encoding IDLE/CHECK/GRANT/SETTLE.
  - Credit widths 8 and 12.
- Sub-module bridge_fc_check: combinational eligibility for one type (req, has_data, len, hdr credits, data credits → eligible), instantiated three times.

Test Plan:
- Reset: Arb_RST low with Req = 3'b111 → Gnt = 0, Busy = 0, fc_sel = 3'b100. After release, Gnt = 3'b001 on the 2nd edge (ph = 8, pd = 64).
- Round-robin: all three requests held with ample credits, Done after each grant, SETTLE_CYCLES = 4 → grant order 001, 010, 100, 001. Each grant starts 6 cycles after the previous Done.
- Data credit boundary: posted, len = 16, pd = 4 → granted. With pd = 3 → no grant and Blocked = 3'b001. Raising pd to 4 → granted and Blocked clears. len = 0 with pd = 255 → blocked.
- Header starvation: nph = 0 with a non-posted read (Data = 0) → Blocked[1] = 1 and posted is still granted. Setting nph = 1 → non-posted granted.
- Timeout: TIMEOUT_CYCLES = 8, no Done → Gnt drops after 8 cycles and Timeout pulses once. Done on the same edge as expiry → no Timeout pulse.
- Ready/reset mid-op: Ready low in CHECK → no grant. Arb_RST low during GRANT → Gnt = 0 asynchronously, state IDLE, pointer = 0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the PCIe Tx arbiter.
// Type indices, FC view select, credit widths and FSM states.
package bridge_pkg;

  localparam int unsigned TYPE_P   = 0;
  localparam int unsigned TYPE_NP  = 1;
  localparam int unsigned TYPE_CPL = 2;

  localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;

  localparam int HDR_CW  = 8;
  localparam int DATA_CW = 12;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    GRANT,
    SETTLE
  } arb_state_e;

endpackage

// File: rtl/bridge_tx_arbiter_if.sv
// Tx arbiter bundle: requests, credits, grant and status.
// master = control/requester side, slave = arbiter.
interface bridge_tx_arbiter_if #(
  parameter int LEN_W = 10
);
  import bridge_pkg::*;

  logic                 Arb_Ready;
  logic [2:0]           Arb_Req;
  logic [2:0]           Arb_Req_Data;
  logic [3*LEN_W-1:0]   Arb_Req_Len;
  logic                 Arb_Done;
  logic [HDR_CW-1:0]    Arb_fc_ph;
  logic [HDR_CW-1:0]    Arb_fc_nph;
  logic [HDR_CW-1:0]    Arb_fc_cplh;
  logic [DATA_CW-1:0]   Arb_fc_pd;
  logic [DATA_CW-1:0]   Arb_fc_npd;
  logic [DATA_CW-1:0]   Arb_fc_cpld;
  logic [2:0]           Arb_fc_sel;
  logic [2:0]           Arb_Gnt;
  logic                 Arb_Busy;
  logic [2:0]           Arb_Blocked;
  logic                 Arb_Timeout;

  modport master (
    output Arb_Ready, Arb_Req, Arb_Req_Data,
    output Arb_Req_Len, Arb_Done,
    output Arb_fc_ph, Arb_fc_nph, Arb_fc_cplh,
    output Arb_fc_pd, Arb_fc_npd, Arb_fc_cpld,
    input  Arb_fc_sel, Arb_Gnt, Arb_Busy,
    input  Arb_Blocked, Arb_Timeout
  );

  modport slave (
    input  Arb_Ready, Arb_Req, Arb_Req_Data,
    input  Arb_Req_Len, Arb_Done,
    input  Arb_fc_ph, Arb_fc_nph, Arb_fc_cplh,
    input  Arb_fc_pd, Arb_fc_npd, Arb_fc_cpld,
    output Arb_fc_sel, Arb_Gnt, Arb_Busy,
    output Arb_Blocked, Arb_Timeout
  );

endinterface

// File: rtl/bridge_fc_check.sv
// Credit eligibility of one TLP type.
// Len 0 means 1024 DW; data need is ceil(len/4).
module bridge_fc_check
  import bridge_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic               req,
  input  logic               has_data,
  input  logic [LEN_W-1:0]   len,
  input  logic [HDR_CW-1:0]  hdr_cr,
  input  logic [DATA_CW-1:0] data_cr,
  output logic               eligible
);

  localparam logic [LEN_W:0] RND =
    {{(LEN_W-1){1'b0}}, 2'b11};

  logic [LEN_W:0]     len_ext;
  logic [LEN_W:0]     need_sh;
  logic [DATA_CW-1:0] need;

  // Data credits needed and the resulting eligibility
  always_comb begin
    len_ext  = {(len == '0), len};
    need_sh  = (len_ext + RND) >> 2;
    need     = has_data ? DATA_CW'(need_sh) : '0;
    eligible = req
             & (hdr_cr != '0)
             & (data_cr >= need);
  end

endmodule

// File: rtl/bridge_tx_arbiter.sv
// Round-robin, credit-gated arbiter for the shared Tx path.
// Grants one TLP type at a time with a settle gap after each.
module bridge_tx_arbiter
  import bridge_pkg::*;
#(
  parameter int LEN_W          = 10,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                Arb_CLK,
  input  logic                Arb_RST,
  bridge_tx_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] SET_LD =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  arb_state_e         state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [2:0]         blk_q, blk_d;
  logic               to_q, to_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;

  logic [2:0]         elig;
  logic               win_vld;
  logic [1:0]         win_idx;
  logic [1:0]         ptr_nx;

  logic [HDR_CW-1:0]  hdr_cr  [3];
  logic [DATA_CW-1:0] data_cr [3];

  assign hdr_cr[TYPE_P]    = bus.Arb_fc_ph;
  assign hdr_cr[TYPE_NP]   = bus.Arb_fc_nph;
  assign hdr_cr[TYPE_CPL]  = bus.Arb_fc_cplh;
  assign data_cr[TYPE_P]   = bus.Arb_fc_pd;
  assign data_cr[TYPE_NP]  = bus.Arb_fc_npd;
  assign data_cr[TYPE_CPL] = bus.Arb_fc_cpld;

  for (genvar g = 0; g < 3; g++) begin : g_fc
    bridge_fc_check #(
      .LEN_W (LEN_W)
    ) u_fc (
      .req      (bus.Arb_Req[g]),
      .has_data (bus.Arb_Req_Data[g]),
      .len      (bus.Arb_Req_Len[g*LEN_W +: LEN_W]),
      .hdr_cr   (hdr_cr[g]),
      .data_cr  (data_cr[g]),
      .eligible (elig[g])
    );
  end

  // First eligible type searching upward from the pointer
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = 2'd0;
    idx     = 0;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % 3;
      if (elig[idx]) begin
        win_vld = 1'b1;
        win_idx = 2'(idx);
      end
    end
    ptr_nx = (win_idx == 2'd2) ? 2'd0
                               : win_idx + 2'd1;
  end

  // Next state, grant, blocked flags and counters
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    blk_d   = blk_q & bus.Arb_Req;
    to_d    = 1'b0;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Arb_Ready && |bus.Arb_Req)
          state_d = CHECK;
      end
      CHECK: begin
        if (!bus.Arb_Ready) begin
          state_d = IDLE;
        end else begin
          blk_d = bus.Arb_Req & ~elig;
          if (win_vld) begin
            state_d        = GRANT;
            gnt_d          = 3'b001 << win_idx;
            blk_d[win_idx] = 1'b0;
            ptr_d          = ptr_nx;
            tcnt_d         = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT: begin
        tcnt_d = tcnt_q + ONE;
        if (bus.Arb_Done || tcnt_q == TMO_LAST) begin
          state_d = SETTLE;
          gnt_d   = '0;
          scnt_d  = SET_LD;
          to_d    = ~bus.Arb_Done;
        end
      end
      SETTLE: begin
        if (scnt_q == '0)
          state_d = IDLE;
        else
          scnt_d = scnt_q - ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge Arb_CLK or negedge Arb_RST) begin
    if (!Arb_RST) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= '0;
      blk_q   <= '0;
      to_q    <= 1'b0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      blk_q   <= blk_d;
      to_q    <= to_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign bus.Arb_fc_sel  = FC_SEL_TX_AVAIL;
  assign bus.Arb_Gnt     = gnt_q;
  assign bus.Arb_Busy    = (state_q != IDLE);
  assign bus.Arb_Blocked = blk_q;
  assign bus.Arb_Timeout = to_q;

endmodule

// File: tb/tb_bridge_tx_arbiter.sv
// Bench for bridge_tx_arbiter: directed vectors, a behavioural
// model checked every cycle, and literal expectations.
module tb_bridge_tx_arbiter;
  import bridge_pkg::*;

  localparam int LEN_W  = 10;
  localparam int SETTLE = 4;
  localparam int TMO    = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  bridge_tx_arbiter_if #(.LEN_W(LEN_W)) bus ();

  bridge_tx_arbiter #(
    .LEN_W          (LEN_W),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (11)
  ) dut (
    .Arb_CLK (clk),
    .Arb_RST (rst_n),
    .bus     (bus.slave)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_CHECK, M_GRANT, M_SETTLE} mph_e;

  mph_e       ph, n_ph;
  int         rr, n_rr, held, n_held, left, n_left, w;
  logic [2:0] m_gnt, n_gnt, m_blk, n_blk;
  logic       m_to, n_to;

  function automatic int need_of(int i);
    int len;
    len = int'(bus.Arb_Req_Len[i*LEN_W +: LEN_W]);
    if (len == 0) len = 1024;
    if (!bus.Arb_Req_Data[i]) return 0;
    return (len + 3) / 4;
  endfunction

  function automatic bit ok(int i);
    int h, d;
    case (i)
      0:       begin h = bus.Arb_fc_ph;   d = bus.Arb_fc_pd;   end
      1:       begin h = bus.Arb_fc_nph;  d = bus.Arb_fc_npd;  end
      default: begin h = bus.Arb_fc_cplh; d = bus.Arb_fc_cpld; end
    endcase
    return bus.Arb_Req[i] && h != 0 && d >= need_of(i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph    <= M_IDLE;
      rr    <= 0;
      held  <= 0;
      left  <= 0;
      m_gnt <= '0;
      m_blk <= '0;
      m_to  <= 1'b0;
    end else begin
      n_ph   = ph;
      n_rr   = rr;
      n_held = held;
      n_left = left;
      n_gnt  = m_gnt;
      n_blk  = m_blk & bus.Arb_Req;
      n_to   = 1'b0;
      w      = -1;
      case (ph)
        M_IDLE:
          if (bus.Arb_Ready && bus.Arb_Req != 0) n_ph = M_CHECK;
        M_CHECK:
          if (!bus.Arb_Ready) n_ph = M_IDLE;
          else begin
            for (int k = 0; k < 3; k++)
              if (w < 0 && ok((rr + k) % 3)) w = (rr + k) % 3;
            for (int i = 0; i < 3; i++)
              n_blk[i] = bus.Arb_Req[i] && !ok(i);
            if (w >= 0) begin
              n_blk[w] = 1'b0;
              n_gnt    = 3'b001 << w;
              n_rr     = (w + 1) % 3;
              n_held   = 0;
              n_ph     = M_GRANT;
            end else n_ph = M_IDLE;
          end
        M_GRANT: begin
          n_held = held + 1;
          if (bus.Arb_Done || n_held == TMO) begin
            n_to   = !bus.Arb_Done;
            n_gnt  = '0;
            n_left = SETTLE;
            n_ph   = M_SETTLE;
          end
        end
        default: begin
          n_left = left - 1;
          if (n_left == 0) n_ph = M_IDLE;
        end
      endcase
      ph    <= n_ph;
      rr    <= n_rr;
      held  <= n_held;
      left  <= n_left;
      m_gnt <= n_gnt;
      m_blk <= n_blk;
      m_to  <= n_to;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_gnt",     bus.Arb_Gnt,     m_gnt);
    chk("m_busy",    bus.Arb_Busy,    ph != M_IDLE);
    chk("m_blocked", bus.Arb_Blocked, m_blk);
    chk("m_timeout", bus.Arb_Timeout, m_to);
    chk("m_fc_sel",  bus.Arb_fc_sel,  3'b100);
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_done();
    bus.Arb_Done = 1'b1;
    @(negedge clk);
    bus.Arb_Done = 1'b0;
  endtask

  task automatic grant_after_done(string nm, logic [2:0] exp);
    int n;
    pulse_done();
    n = 0;
    while (bus.Arb_Gnt == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_gnt"}, bus.Arb_Gnt, exp);
    chk({nm, "_gap"}, n, 6);
  endtask

  task automatic release_all();
    bus.Arb_Req = 3'b000;
    pulse_done();
    step(8);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.Arb_Ready    = 1'b1;
    bus.Arb_Req      = 3'b111;
    bus.Arb_Req_Data = 3'b101;
    bus.Arb_Req_Len  = {10'd16, 10'd16, 10'd16};
    bus.Arb_Done     = 1'b0;
    bus.Arb_fc_ph    = 8'd8;
    bus.Arb_fc_nph   = 8'd8;
    bus.Arb_fc_cplh  = 8'd8;
    bus.Arb_fc_pd    = 12'd64;
    bus.Arb_fc_npd   = 12'd64;
    bus.Arb_fc_cpld  = 12'd64;
    step(2);
    chk("rst_gnt",    bus.Arb_Gnt,    3'b000);
    chk("rst_busy",   bus.Arb_Busy,   1'b0);
    chk("rst_fc_sel", bus.Arb_fc_sel, 3'b100);
    rst_n = 1'b1;
    step(1);
    chk("first_edge_gnt", bus.Arb_Gnt, 3'b000);
    step(1);
    chk("first_gnt", bus.Arb_Gnt, 3'b001);

    // Round-robin with all three requesting
    grant_after_done("rr1", 3'b010);
    grant_after_done("rr2", 3'b100);
    grant_after_done("rr3", 3'b001);
    release_all();
    chk("idle_busy", bus.Arb_Busy, 1'b0);

    // Posted data credit boundary: len 16 needs 4
    bus.Arb_fc_pd = 12'd4;
    bus.Arb_Req   = 3'b001;
    step(2);
    chk("pd4_gnt", bus.Arb_Gnt, 3'b001);
    release_all();
    bus.Arb_fc_pd = 12'd3;
    bus.Arb_Req   = 3'b001;
    step(2);
    chk("pd3_gnt", bus.Arb_Gnt, 3'b000);
    chk("pd3_blk", bus.Arb_Blocked, 3'b001);
    bus.Arb_fc_pd = 12'd4;
    step(2);
    chk("pd4b_gnt", bus.Arb_Gnt, 3'b001);
    chk("pd4b_blk", bus.Arb_Blocked, 3'b000);
    release_all();

    // len 0 means 1024 DW, needs 256 credits
    bus.Arb_Req_Len[9:0] = 10'd0;
    bus.Arb_fc_pd        = 12'd255;
    bus.Arb_Req          = 3'b001;
    step(2);
    chk("len0_gnt", bus.Arb_Gnt, 3'b000);
    chk("len0_blk", bus.Arb_Blocked, 3'b001);
    bus.Arb_Req = 3'b000;
    step(1);
    chk("withdraw_blk", bus.Arb_Blocked, 3'b000);
    bus.Arb_Req_Len[9:0] = 10'd16;
    bus.Arb_fc_pd        = 12'd64;
    step(4);

    // Header starvation on non-posted
    bus.Arb_fc_nph = 8'd0;
    bus.Arb_Req    = 3'b011;
    step(2);
    chk("nph0_gnt", bus.Arb_Gnt, 3'b001);
    chk("nph0_blk", bus.Arb_Blocked, 3'b010);
    bus.Arb_Req    = 3'b010;
    bus.Arb_fc_nph = 8'd1;
    grant_after_done("nph1", 3'b010);
    chk("nph1_blk", bus.Arb_Blocked, 3'b000);
    release_all();

    // Timeout with no Done
    bus.Arb_Req = 3'b100;
    step(2);
    chk("to_gnt", bus.Arb_Gnt, 3'b100);
    bus.Arb_Req = 3'b000;
    step(7);
    chk("to_hold_gnt", bus.Arb_Gnt, 3'b100);
    chk("to_hold_pulse", bus.Arb_Timeout, 1'b0);
    step(1);
    chk("to_drop_gnt", bus.Arb_Gnt, 3'b000);
    chk("to_pulse", bus.Arb_Timeout, 1'b1);
    step(1);
    chk("to_pulse_end", bus.Arb_Timeout, 1'b0);
    step(6);

    // Done on the expiry edge wins
    bus.Arb_Req = 3'b001;
    step(2);
    chk("tod_gnt", bus.Arb_Gnt, 3'b001);
    bus.Arb_Req = 3'b000;
    step(7);
    pulse_done();
    chk("tod_drop", bus.Arb_Gnt, 3'b000);
    chk("tod_nopulse", bus.Arb_Timeout, 1'b0);
    step(8);

    // Ready dropped while in CHECK
    bus.Arb_Req = 3'b010;
    step(1);
    bus.Arb_Ready = 1'b0;
    step(1);
    chk("rdy_gnt", bus.Arb_Gnt, 3'b000);
    chk("rdy_busy", bus.Arb_Busy, 1'b0);
    step(2);
    chk("rdy_hold", bus.Arb_Gnt, 3'b000);
    bus.Arb_Ready = 1'b1;
    step(2);
    chk("rdy_gnt2", bus.Arb_Gnt, 3'b010);

    // Async reset during GRANT
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", bus.Arb_Gnt, 3'b000);
    chk("arst_busy", bus.Arb_Busy, 1'b0);
    step(2);
    rst_n       = 1'b1;
    bus.Arb_Req = 3'b111;
    step(2);
    chk("arst_ptr0", bus.Arb_Gnt, 3'b001);
    release_all();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

endmodule
